trap_handler: RTL and testbench
===============================

TRAP_HANDLER -- requirements
Module: trap_handler

Interface
REQ-001 Parameter: MTVEC_RESET, 32'h00000010, mtvec value after reset.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 exception  in  1  synchronous exception flag from the exception checker.
REQ-005 interrup  in  1  interrupt request flag from the exception checker.
REQ-006 excep_info  in  32  cause code from the checker; bit31=1 interrupt, bits[30:0] code.
REQ-007 pc  in  32  address of the faulting or interrupted instruction.
REQ-008 tval  in  32  faulting address or instruction word.
REQ-009 mret  in  1  decoded MRET in current instruction.
REQ-010 irq_ext  in  1  external interrupt line, level-sensitive.
REQ-011 csr_addr  in  12  CSR index for the software access port.
REQ-012 csr_we  in  1  CSR write strobe.
REQ-013 csr_wdata  in  32  CSR write data.
REQ-014 csr_rdata  out  32  combinational read data for csr_addr.
REQ-015 mstatus  out  32  mstatus register, fed back to the exception checker.
REQ-016 mip  out  32  mip register, fed back to the exception checker.
REQ-017 redirect  out  1  one-cycle PC redirect / pipeline flush strobe.
REQ-018 redirect_pc  out  32  target PC, valid while redirect=1, else 0.
REQ-019 busy  out  1  high whenever state != IDLE.

Function
REQ-020 CSR map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip; other addresses read 0, writes ignored.
REQ-021 mstatus[0]=MIE (global interrupt enable), mstatus[1]=MPIE; bits[31:2] read 0, writes to them ignored.
REQ-022 mip[0] <= irq_ext every cycle; mip[31:1]=0; mip is read-only via CSR port.
REQ-023 mtvec and mepc bits[1:0] forced to 0 on every write.
REQ-024 FSM states IDLE, TRAP, RET; TRAP and RET each last exactly one cycle, then IDLE.
REQ-025 IDLE, trap condition = exception | (interrup & mstatus[0]).
REQ-026 IDLE & trap condition, on edge: mepc<=pc&~3, mcause<=excep_info, mtval<=tval, MPIE<=MIE, MIE<=0, state<=TRAP.
REQ-027 TRAP: redirect=1, redirect_pc=mtvec.
REQ-028 IDLE & mret & no trap condition, on edge: MIE<=MPIE, MPIE<=1, state<=RET.
REQ-029 RET: redirect=1, redirect_pc=mepc.
REQ-030 Latency: redirect asserts the cycle after the event edge, for exactly one cycle.
REQ-031 Priority: exception > enabled interrupt > mret > CSR write.
REQ-032 CSR write in same cycle as an accepted trap or mret is dropped.
REQ-033 In TRAP or RET, exception, interrup, mret and csr_we are ignored (flushed instructions).
REQ-034 interrup with mstatus[0]=0 causes no state change.
REQ-035 CSR write takes effect on the edge; csr_rdata reflects the new value the following cycle.

Reset
REQ-036 On rst=1 at an edge: state=IDLE, mstatus=0, mip=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mtval=0; overrides all other inputs.
REQ-037 During and immediately after reset: redirect=0, redirect_pc=0, busy=0.
REQ-038 rst asserted while in TRAP or RET returns to IDLE without redirect on the following cycle.

Verification
REQ-039 Illegal opcode: exception=1, excep_info=2, pc=0x8, tval=0x000072FF -> next cycle redirect=1, redirect_pc=0x10; mepc=0x8, mcause=2, mtval=0x000072FF, mstatus=0.
REQ-040 Interrupt gating: mstatus=0, interrup=1 -> no redirect; write mstatus=1, interrup=1, excep_info=0x8000000B -> redirect to mtvec, mstatus=0x2.
REQ-041 MRET: after REQ-040 trap, mret=1 -> next cycle redirect=1, redirect_pc=mepc; mstatus=0x3.
REQ-042 Collision: exception=1, mret=1, csr_we=1 to mtvec=0x40 same cycle -> trap taken, mtvec stays 0x10, mstatus[1:0] per trap.
REQ-043 Busy window: second exception during TRAP -> ignored, mepc unchanged, single redirect pulse.
REQ-044 Reset mid-TRAP: rst=1 in TRAP -> all CSRs at reset values, redirect=0, state IDLE; write mtvec=0x103 -> reads 0x100.

Source files
------------

// File: rtl/trap_handler.sv
// Machine-mode trap sequencer: captures trap context, owns the M-mode CSRs and
// emits a one-cycle redirect strobe toward mtvec on a trap or mepc on MRET.
//
// state | meaning
// IDLE  | normal execution; accepts traps, MRET and CSR writes
// TRAP  | trap taken; redirect to mtvec this cycle
// RET   | MRET taken; redirect to mepc this cycle
module trap_handler #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        interrup,
  input  logic [31:0] excep_info,
  input  logic [31:0] pc,
  input  logic [31:0] tval,
  input  logic        mret,
  input  logic        irq_ext,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [31:0] mstatus,
  output logic [31:0] mip,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

  state_t      state_q, state_d;
  logic        mie_q, mpie_q, mip0_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q;
  logic        trap_take, mret_take, csr_wr;

  // Everything arriving during TRAP/RET belongs to flushed instructions.
  always_comb begin
    state_d   = state_q;
    trap_take = 1'b0;
    mret_take = 1'b0;
    csr_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        trap_take = exception | (interrup & mie_q);
        mret_take = mret & ~trap_take;
        csr_wr    = csr_we & ~trap_take & ~mret_take;
        if (trap_take)      state_d = TRAP;
        else if (mret_take) state_d = RET;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mip0_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      state_q <= state_d;
      mip0_q  <= irq_ext;
      if (trap_take) begin
        mepc_q   <= {pc[31:2], 2'b00};
        mcause_q <= excep_info;
        mtval_q  <= tval;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_take) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_wr) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie_q  <= csr_wdata[0];
            mpie_q <= csr_wdata[1];
          end
          ADDR_MTVEC:  mtvec_q  <= {csr_wdata[31:2], 2'b00};
          ADDR_MEPC:   mepc_q   <= {csr_wdata[31:2], 2'b00};
          ADDR_MCAUSE: mcause_q <= csr_wdata;
          ADDR_MTVAL:  mtval_q  <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  assign mstatus = {30'd0, mpie_q, mie_q};
  assign mip     = {31'd0, mip0_q};

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = mstatus;
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      ADDR_MTVAL:   csr_rdata = mtval_q;
      ADDR_MIP:     csr_rdata = mip;
      default:      csr_rdata = '0;
    endcase
  end

  // Outputs are masked by rst so a reset landing on TRAP/RET never flushes.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    busy        = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        TRAP: begin
          redirect    = 1'b1;
          redirect_pc = mtvec_q;
        end
        RET: begin
          redirect    = 1'b1;
          redirect_pc = mepc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_handler.sv
// Directed bench for trap_handler: expected redirect targets are queued by the
// stimulus and popped by an independent monitor; CSR state is checked inline.
module tb_trap_handler;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception, interrup, mret, irq_ext, csr_we;
  logic [31:0] excep_info, pc, tval, csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, mstatus, mip, redirect_pc;
  logic        redirect, busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  trap_handler #(.MTVEC_RESET(32'h0000_0010)) dut (
    .clk(clk), .rst(rst), .exception(exception), .interrup(interrup),
    .excep_info(excep_info), .pc(pc), .tval(tval), .mret(mret),
    .irq_ext(irq_ext), .csr_addr(csr_addr), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .mstatus(mstatus),
    .mip(mip), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    exception = 0; interrup = 0; mret = 0; csr_we = 0;
    excep_info = '0; pc = '0; tval = '0; csr_wdata = '0; csr_addr = '0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_addr = addr; csr_wdata = data; csr_we = 1;
    tick();
    quiet();
  endtask

  // Monitor: every redirect pulse must match the next queued target.
  always @(negedge clk) begin
    if (redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect: got pc 0x%08h expected no redirect", redirect_pc);
      end else begin
        check("redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end else if (redirect_pc !== 32'd0) begin
      check("redirect_pc_idle", redirect_pc, 32'd0);
    end
  end

  initial begin
    rst = 1; irq_ext = 0;
    quiet();
    tick();
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 0;
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    rd("reset_mstatus", 12'h300, 32'h0);
    rd("reset_mtvec",   12'h305, 32'h10);
    rd("reset_mepc",    12'h341, 32'h0);
    rd("reset_mcause",  12'h342, 32'h0);
    rd("reset_mtval",   12'h343, 32'h0);
    rd("reset_mip",     12'h344, 32'h0);
    rd("unmapped_rd",   12'h123, 32'h0);

    // Illegal-opcode exception.
    exception = 1; excep_info = 32'd2; pc = 32'h8; tval = 32'h0000_72FF;
    exp_q.push_back(32'h10);
    tick();
    quiet();
    check("trap_busy", {31'd0, busy}, 32'd1);
    tick();
    check("post_trap_busy", {31'd0, busy}, 32'd0);
    rd("ill_mepc",   12'h341, 32'h8);
    rd("ill_mcause", 12'h342, 32'h2);
    rd("ill_mtval",  12'h343, 32'h0000_72FF);
    check("ill_mstatus", mstatus, 32'h0);

    // mip mirrors irq_ext and ignores writes.
    irq_ext = 1;
    tick();
    check("mip_set", mip, 32'h1);
    wr(12'h344, 32'h0);
    rd("mip_ro", 12'h344, 32'h1);
    irq_ext = 0;
    tick();
    check("mip_clr", mip, 32'h0);

    // Interrupt masked while MIE=0.
    interrup = 1; excep_info = 32'h8000_000B; pc = 32'h20;
    tick();
    quiet();
    tick();
    check("masked_busy", {31'd0, busy}, 32'd0);
    check("masked_mstatus", mstatus, 32'h0);

    // Enable MIE; upper bits ignored and MPIE written from bit 1 (0 here).
    wr(12'h300, 32'hFFFF_FFFD);
    rd("mstatus_wr", 12'h300, 32'h1);
    interrup = 1; excep_info = 32'h8000_000B; pc = 32'h24;
    exp_q.push_back(32'h10);
    tick();
    quiet();
    check("irq_mstatus", mstatus, 32'h2);
    tick();
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mepc",   12'h341, 32'h24);

    // MRET back to mepc.
    mret = 1;
    exp_q.push_back(32'h24);
    tick();
    quiet();
    check("mret_mstatus", mstatus, 32'h3);
    tick();

    // Exception + mret + mtvec write in one cycle: trap wins, write dropped.
    exception = 1; mret = 1; csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h40;
    excep_info = 32'd4; pc = 32'h33; tval = 32'h1234;
    exp_q.push_back(32'h10);
    tick();
    quiet();
    check("coll_mstatus", mstatus, 32'h2);
    tick();
    rd("coll_mtvec", 12'h305, 32'h10);
    rd("coll_mepc",  12'h341, 32'h30);

    // MRET + CSR write: mret wins, write dropped.
    mret = 1; csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h80;
    exp_q.push_back(32'h30);
    tick();
    quiet();
    check("mret_wr_mstatus", mstatus, 32'h3);
    tick();
    rd("mret_wr_mtvec", 12'h305, 32'h10);

    // Second exception and write during TRAP are ignored.
    exception = 1; excep_info = 32'd1; pc = 32'h40;
    exp_q.push_back(32'h10);
    tick();
    pc = 32'h44; csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h80;
    tick();
    quiet();
    tick();
    rd("busywin_mepc",  12'h341, 32'h40);
    rd("busywin_mtvec", 12'h305, 32'h10);
    check("busywin_mstatus", mstatus, 32'h2);

    // mepc low bits forced clear on write.
    wr(12'h341, 32'h107);
    rd("mepc_align", 12'h341, 32'h104);

    // Reset landing on TRAP: no redirect, all CSRs back to reset values.
    exception = 1; excep_info = 32'd3; pc = 32'h50; tval = 32'h5;
    tick();
    quiet();
    rst = 1;
    #1;
    check("rst_trap_redirect", {31'd0, redirect}, 32'd0);
    check("rst_trap_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 0;
    #1;
    check("post_rst_redirect", {31'd0, redirect}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    rd("post_rst_mepc",    12'h341, 32'h0);
    rd("post_rst_mcause",  12'h342, 32'h0);
    rd("post_rst_mtval",   12'h343, 32'h0);
    rd("post_rst_mtvec",   12'h305, 32'h10);
    check("post_rst_mstatus", mstatus, 32'h0);
    tick();
    wr(12'h305, 32'h103);
    rd("mtvec_align", 12'h305, 32'h100);

    // New vector is used by the next trap.
    exception = 1; excep_info = 32'd2; pc = 32'h60;
    exp_q.push_back(32'h100);
    tick();
    quiet();
    tick();
    tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
